// File: rtl/aemb_wbarb_if.sv
// aemb_wbarb_if: three-master and external WISHBONE signal bundle for the aeMB bus arbiter
interface aemb_wbarb_if #(parameter int ASIZ = 32);
  logic [ASIZ-1:0] iwb_adr_i, dwb_adr_i, xwb_adr_i, wb_adr_o;
  logic [31:0] iwb_dat_o, dwb_dat_i, dwb_dat_o, xwb_dat_i, xwb_dat_o, wb_dat_o, wb_dat_i;
  logic [3:0] dwb_sel_i, xwb_sel_i, wb_sel_o;
  logic iwb_stb_i, iwb_ack_o, dwb_we_i, dwb_stb_i, dwb_ack_o, xwb_we_i, xwb_stb_i, xwb_ack_o;
  logic wb_stb_o, wb_wre_o, wb_ack_i, wb_tmo_o;
  logic [1:0] gnt_o;
  modport master (
    input iwb_adr_i, iwb_stb_i, dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_we_i, dwb_stb_i,
          xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_we_i, xwb_stb_i, wb_dat_i, wb_ack_i,
    output iwb_ack_o, iwb_dat_o, dwb_ack_o, dwb_dat_o, xwb_ack_o, xwb_dat_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_wre_o, wb_tmo_o, gnt_o
  );
  modport slave (
    output iwb_adr_i, iwb_stb_i, dwb_adr_i, dwb_dat_i, dwb_sel_i, dwb_we_i, dwb_stb_i,
           xwb_adr_i, xwb_dat_i, xwb_sel_i, xwb_we_i, xwb_stb_i, wb_dat_i, wb_ack_i,
    input iwb_ack_o, iwb_dat_o, dwb_ack_o, dwb_dat_o, xwb_ack_o, xwb_dat_o,
          wb_adr_o, wb_dat_o, wb_sel_o, wb_stb_o, wb_wre_o, wb_tmo_o, gnt_o
  );
endinterface

// File: rtl/aemb_wbarb.sv
// aemb_wbarb: round-robin three-master WISHBONE arbiter with a bus watchdog
module aemb_wbarb #(
  parameter int ASIZ = 32,
  parameter int TMOW = 8,
  parameter int TMO = 255
) (
  input logic sys_clk_i,
  input logic sys_rst_i,
  aemb_wbarb_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RETIRE} state_t;
  state_t state;
  logic [TMOW-1:0] wdt;
  logic [2:0] req;
  logic [1:0] c1, c2, win;
  logic [ASIZ-1:0] adr;
  logic [31:0] dat, rsp;
  logic [3:0] sel;
  logic we, done;
  always_comb begin
    req = {bus.xwb_stb_i, bus.dwb_stb_i, bus.iwb_stb_i};
    c1 = bus.gnt_o == 2'd0 ? 2'd1 : bus.gnt_o == 2'd1 ? 2'd2 : 2'd0;
    c2 = c1 == 2'd0 ? 2'd1 : c1 == 2'd1 ? 2'd2 : 2'd0;
    win = req[c1] ? c1 : req[c2] ? c2 : bus.gnt_o;
    adr = win == 2'd0 ? bus.iwb_adr_i : win == 2'd1 ? bus.dwb_adr_i : bus.xwb_adr_i;
    dat = win == 2'd0 ? 32'd0 : win == 2'd1 ? bus.dwb_dat_i : bus.xwb_dat_i;
    sel = win == 2'd0 ? 4'hF : win == 2'd1 ? bus.dwb_sel_i : bus.xwb_sel_i;
    we = win == 2'd1 ? bus.dwb_we_i : (win == 2'd2) && bus.xwb_we_i;
    // an ack arriving on the watchdog's last cycle still delivers real data
    done = bus.wb_ack_i || wdt == TMOW'(TMO);
    rsp = bus.wb_ack_i ? bus.wb_dat_i : 32'hDEADBEEF;
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state <= IDLE;
      wdt <= '0;
      bus.gnt_o <= 2'd2;
      bus.iwb_ack_o <= 1'b0;
      bus.dwb_ack_o <= 1'b0;
      bus.xwb_ack_o <= 1'b0;
      bus.iwb_dat_o <= '0;
      bus.dwb_dat_o <= '0;
      bus.xwb_dat_o <= '0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_wre_o <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel_o <= '0;
      bus.wb_tmo_o <= 1'b0;
    end else begin
      bus.iwb_ack_o <= 1'b0;
      bus.dwb_ack_o <= 1'b0;
      bus.xwb_ack_o <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state <= BUSY;
          wdt <= '0;
          bus.gnt_o <= win;
          bus.wb_adr_o <= adr;
          bus.wb_dat_o <= dat;
          bus.wb_sel_o <= sel;
          bus.wb_wre_o <= we;
          bus.wb_stb_o <= 1'b1;
        end
        BUSY: if (done) begin
          state <= RETIRE;
          wdt <= '0;
          bus.wb_stb_o <= 1'b0;
          bus.wb_wre_o <= 1'b0;
          if (!bus.wb_ack_i) bus.wb_tmo_o <= 1'b1;
          if (bus.gnt_o == 2'd0) begin
            bus.iwb_dat_o <= rsp;
            bus.iwb_ack_o <= 1'b1;
          end
          if (bus.gnt_o == 2'd1) begin
            bus.dwb_dat_o <= rsp;
            bus.dwb_ack_o <= 1'b1;
          end
          if (bus.gnt_o == 2'd2) begin
            bus.xwb_dat_o <= rsp;
            bus.xwb_ack_o <= 1'b1;
          end
        end else wdt <= wdt + TMOW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aemb_wbarb.sv
// tb_aemb_wbarb: directed and randomized transaction-level check of the WISHBONE arbiter
module tb_aemb_wbarb;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, cyc = 0, last = 2, ack_cyc = 0, prev = 0;
  logic tmo_exp = 1'b0;
  logic [31:0] exp_dat [3];
  logic [31:0] m_adr [3];
  logic [31:0] m_dat [3];
  logic [3:0] m_sel [3];
  logic m_we [3];
  logic [2:0] m_req = 3'b000;
  aemb_wbarb_if #(.ASIZ(32)) f();
  aemb_wbarb #(.ASIZ(32), .TMOW(8), .TMO(TMO)) dut (.sys_clk_i(clk), .sys_rst_i(rst), .bus(f.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] acks();
    return {f.xwb_ack_o, f.dwb_ack_o, f.iwb_ack_o};
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return m == 0 ? f.iwb_dat_o : m == 1 ? f.dwb_dat_o : f.xwb_dat_o;
  endfunction

  // round robin: first requester after the last granted master
  function automatic int pick();
    for (int k = 1; k <= 3; k++)
      if (m_req[(last + k) % 3]) return (last + k) % 3;
    return 0;
  endfunction

  task automatic drive();
    f.iwb_adr_i = m_adr[0];
    f.iwb_stb_i = m_req[0];
    f.dwb_adr_i = m_adr[1];
    f.dwb_dat_i = m_dat[1];
    f.dwb_sel_i = m_sel[1];
    f.dwb_we_i = m_we[1];
    f.dwb_stb_i = m_req[1];
    f.xwb_adr_i = m_adr[2];
    f.xwb_dat_i = m_dat[2];
    f.xwb_sel_i = m_sel[2];
    f.xwb_we_i = m_we[2];
    f.xwb_stb_i = m_req[2];
  endtask

  task automatic model_reset();
    last = 2;
    tmo_exp = 1'b0;
    for (int i = 0; i < 3; i++) exp_dat[i] = 32'd0;
  endtask

  task automatic do_reset();
    m_req = 3'b000;
    drive();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_gnt", f.gnt_o, 2);
    chk("rst_stb", f.wb_stb_o, 0);
  endtask

  task automatic randomize_masters();
    for (int i = 0; i < 3; i++) begin
      m_adr[i] = $urandom;
      m_dat[i] = $urandom;
      m_sel[i] = 4'($urandom_range(0, 15));
      m_we[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // one transfer: waits = ack-free stb cycles before the slave acks
  task automatic xfer(input int waits, input logic [31:0] rdata, input bit drop);
    int m;
    int n;
    logic [31:0] want;
    m = pick();
    n = 0;
    while (!f.wb_stb_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("stb_rise", f.wb_stb_o, 1);
    chk("gnt", f.gnt_o, m);
    chk("adr", f.wb_adr_o, m_adr[m]);
    chk("sel", f.wb_sel_o, m == 0 ? 4'hF : m_sel[m]);
    chk("wre", f.wb_wre_o, m == 0 ? 1'b0 : m_we[m]);
    if (m != 0) chk("wdat", f.wb_dat_o, m_dat[m]);
    if (drop) begin
      m_req = 3'b000;
      drive();
    end
    for (int c = 0; ; c++) begin
      f.wb_ack_i = (c == waits);
      f.wb_dat_i = rdata;
      @(negedge clk);
      f.wb_ack_i = 1'b0;
      if (c == waits || c == TMO) break;
      chk("stb_hold", f.wb_stb_o, 1);
    end
    want = waits <= TMO ? rdata : 32'hDEADBEEF;
    if (waits > TMO) tmo_exp = 1'b1;
    exp_dat[m] = want;
    last = m;
    ack_cyc = cyc;
    chk("stb_fall", f.wb_stb_o, 0);
    chk("wre_fall", f.wb_wre_o, 0);
    chk("ack", acks(), 3'b001 << m);
    for (int i = 0; i < 3; i++) chk($sformatf("dat%0d", i), dat_of(i), exp_dat[i]);
    chk("tmo", f.wb_tmo_o, tmo_exp);
    @(negedge clk);
    chk("ack_once", acks(), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_adr[i] = 32'd0;
      m_dat[i] = 32'd0;
      m_sel[i] = 4'd0;
      m_we[i] = 1'b0;
    end
    model_reset();
    f.wb_ack_i = 1'b0;
    f.wb_dat_i = 32'd0;
    drive();
    repeat (2) @(negedge clk);
    chk("r_stb", f.wb_stb_o, 0);
    chk("r_wre", f.wb_wre_o, 0);
    chk("r_gnt", f.gnt_o, 2);
    chk("r_tmo", f.wb_tmo_o, 0);
    chk("r_ack", acks(), 0);
    chk("r_adr", f.wb_adr_o, 0);
    chk("r_sel", f.wb_sel_o, 0);
    chk("r_wdat", f.wb_dat_o, 0);
    for (int i = 0; i < 3; i++) chk("r_dat", dat_of(i), 0);
    rst = 1'b0;
    m_adr[0] = 32'h100;
    m_req = 3'b001;
    drive();
    xfer(0, 32'h12345678, 1);
    m_adr[1] = 32'h2000;
    m_dat[1] = 32'hCAFEF00D;
    m_sel[1] = 4'b0011;
    m_we[1] = 1'b1;
    m_req = 3'b010;
    drive();
    xfer(2, 32'h0BADF00D, 1);
    do_reset();
    randomize_masters();
    m_req = 3'b111;
    drive();
    for (int t = 0; t < 6; t++) begin
      prev = ack_cyc;
      xfer(0, $urandom, 0);
      if (t > 0) chk("spacing", ack_cyc - prev, 3);
    end
    m_req = 3'b000;
    drive();
    m_we[1] = 1'b0;
    m_req = 3'b010;
    drive();
    xfer(TMO, 32'hA5A50001, 1);
    m_req = 3'b010;
    drive();
    xfer(TMO + 3, 32'h11111111, 1);
    m_adr[2] = 32'h3000;
    m_dat[2] = 32'h0F0F0F0F;
    m_sel[2] = 4'b1100;
    m_we[2] = 1'b1;
    m_req = 3'b100;
    drive();
    xfer(1, 32'h22222222, 1);
    m_req = 3'b001;
    drive();
    for (int n = 0; n < 8 && !f.wb_stb_o; n++) @(negedge clk);
    chk("mid_busy", f.wb_stb_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_stb", f.wb_stb_o, 0);
    chk("mid_gnt", f.gnt_o, 2);
    chk("mid_ack", acks(), 0);
    m_req = 3'b000;
    drive();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_ack2", acks(), 0);
    chk("mid_tmo", f.wb_tmo_o, 0);
    for (int i = 0; i < 3; i++) chk("mid_dat", dat_of(i), 0);
    m_req = 3'b100;
    drive();
    xfer(0, 32'h33333333, 1);
    for (int t = 0; t < 40; t++) begin
      bit drop;
      randomize_masters();
      m_req = 3'($urandom_range(1, 7));
      drop = 1'($urandom_range(0, 1));
      drive();
      xfer($urandom_range(0, TMO + 2), $urandom, drop);
      m_req = 3'b000;
      drive();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
